// File: rtl/uart_async_receiver.sv
// 8N1 UART receiver: oversampled, synchronised and filtered RxD, one-clk byte/error strobes,
// plus idle-gap and end-of-packet detection.
module uart_async_receiver #(
    parameter int unsigned ClkFrequency = 50_000_000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_frame_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int unsigned OvBits   = $clog2(Oversampling);
    localparam int unsigned AccWidth = 16;
    localparam logic [63:0] IncWide  =
        (((64'(Baud) * 64'(Oversampling)) << AccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [AccWidth-1:0] Inc = IncWide[AccWidth-1:0];

    localparam int unsigned GapMax  = 16 * Oversampling;
    localparam int unsigned GapBits = $clog2(GapMax + 1);
    localparam logic [GapBits-1:0] GapSat = GapBits'(GapMax);

    localparam logic [OvBits-1:0] HalfCnt = OvBits'(Oversampling / 2 - 1);
    localparam logic [OvBits-1:0] LastCnt = OvBits'(Oversampling - 1);

    // BIT0..BIT7 and STOP are consecutive so a data bit advances by +1.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        BIT0  = 4'd2,
        BIT1  = 4'd3,
        BIT2  = 4'd4,
        BIT3  = 4'd5,
        BIT4  = 4'd6,
        BIT5  = 4'd7,
        BIT6  = 4'd8,
        BIT7  = 4'd9,
        STOP  = 4'd10,
        BREAK = 4'd11
    } stateT;

    stateT               state;
    stateT               stateNext;
    logic [AccWidth-1:0] tickAcc;
    logic [AccWidth:0]   tickSum;
    logic                OvTick;
    logic [1:0]          rxSync;
    logic [1:0]          filtCnt;
    logic [1:0]          filtNext;
    logic                RxBit;
    logic [OvBits-1:0]   OvCnt;
    logic [7:0]          shiftReg;
    logic [GapBits-1:0]  gapCnt;
    logic                hadByte;
    logic                ovCntClr;
    logic                shiftEn;
    logic                dataLoad;
    logic                frameErr;
    logic                eopHit;

    assign tickSum = {1'b0, tickAcc} + {1'b0, Inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tickAcc <= '0;
            OvTick  <= 1'b0;
        end else begin
            tickAcc <= tickSum[AccWidth-1:0];
            OvTick  <= tickSum[AccWidth];
        end
    end

    always_comb begin
        filtNext = filtCnt;
        if (rxSync[1] && filtCnt != 2'b11) begin
            filtNext = filtCnt + 2'd1;
        end else if (!rxSync[1] && filtCnt != 2'b00) begin
            filtNext = filtCnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxSync  <= '1;
            filtCnt <= '1;
            RxBit   <= 1'b1;
        end else begin
            rxSync <= {rxSync[0], RxD};
            if (OvTick) begin
                filtCnt <= filtNext;
                if (filtNext == 2'b11) begin
                    RxBit <= 1'b1;
                end else if (filtNext == 2'b00) begin
                    RxBit <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        ovCntClr  = 1'b0;
        shiftEn   = 1'b0;
        dataLoad  = 1'b0;
        frameErr  = 1'b0;
        case (state)
            IDLE: begin
                if (OvTick && !RxBit) begin
                    stateNext = START;
                    ovCntClr  = 1'b1;
                end
            end
            START: begin
                if (OvTick && OvCnt == HalfCnt) begin
                    if (RxBit) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = BIT0;
                        ovCntClr  = 1'b1;
                    end
                end
            end
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
                if (OvTick && OvCnt == LastCnt) begin
                    shiftEn   = 1'b1;
                    stateNext = stateT'(state + 4'd1);
                end
            end
            STOP: begin
                if (OvTick && OvCnt == LastCnt) begin
                    if (RxBit) begin
                        dataLoad  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        frameErr  = 1'b1;
                        stateNext = BREAK;
                    end
                end
            end
            BREAK: begin
                if (RxBit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OvCnt <= '0;
        end else if (OvTick) begin
            OvCnt <= ovCntClr ? '0 : OvCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shiftReg        <= '0;
            RxD_data        <= '0;
            RxD_data_ready  <= 1'b0;
            RxD_frame_error <= 1'b0;
        end else begin
            RxD_data_ready  <= dataLoad;
            RxD_frame_error <= frameErr;
            if (shiftEn) begin
                shiftReg <= {RxBit, shiftReg[7:1]};
            end
            if (dataLoad) begin
                RxD_data <= shiftReg;
            end
        end
    end

    // End of packet fires on the same edge the gap counter saturates.
    assign eopHit = (state == IDLE) && OvTick && (gapCnt == GapSat - 1'b1) && hadByte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gapCnt          <= GapSat;
            hadByte         <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else begin
            RxD_endofpacket <= eopHit;
            if (state != IDLE) begin
                gapCnt <= '0;
            end else if (OvTick && gapCnt != GapSat) begin
                gapCnt <= gapCnt + 1'b1;
            end
            if (eopHit) begin
                hadByte <= 1'b0;
            end else if (dataLoad) begin
                hadByte <= 1'b1;
            end
        end
    end

    assign RxD_idle = (gapCnt == GapSat);

endmodule

// File: tb/tb_uart_async_receiver.sv
// Directed bench for uart_async_receiver; line run at 460800 baud on a 50 MHz clock so a bit is ~108.5 clk.
module tb_uart_async_receiver;

    localparam int BitClk   = 108;
    localparam int GlitchSh = 25;
    localparam int GlitchLg = 62;
    localparam int BitSlow  = 111;
    localparam int BitFast  = 106;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD   = 1'b1;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_frame_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    always #10 clk = ~clk;

    uart_async_receiver #(
        .ClkFrequency(50_000_000),
        .Baud(460800),
        .Oversampling(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RxD(RxD),
        .RxD_data_ready(RxD_data_ready),
        .RxD_data(RxD_data),
        .RxD_frame_error(RxD_frame_error),
        .RxD_idle(RxD_idle),
        .RxD_endofpacket(RxD_endofpacket)
    );

    int checks = 0;
    int passes = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         readyCnt   = 0;
    int         ferrCnt    = 0;
    int         eopCnt     = 0;
    int         bothHigh   = 0;
    int         readyLong  = 0;
    int         ferrLong   = 0;
    int         eopLong    = 0;
    int         dataGlitch = 0;
    logic [7:0] rxQ[$];
    logic       monOn      = 1'b0;
    logic       inRst      = 1'b1;
    logic       prevReady  = 1'b0;
    logic       prevFerr   = 1'b0;
    logic       prevEop    = 1'b0;
    logic [7:0] prevData   = 8'h00;

    always @(posedge clk) inRst <= !rst_n;

    always @(negedge clk) begin
        if (monOn) begin
            if (RxD_data_ready) begin
                readyCnt++;
                rxQ.push_back(RxD_data);
            end
            if (RxD_frame_error) ferrCnt++;
            if (RxD_endofpacket) eopCnt++;
            if (RxD_data_ready && RxD_frame_error) bothHigh++;
            if (RxD_data_ready && prevReady) readyLong++;
            if (RxD_frame_error && prevFerr) ferrLong++;
            if (RxD_endofpacket && prevEop) eopLong++;
            if (!inRst && RxD_data != prevData && !RxD_data_ready) dataGlitch++;
        end
        prevReady = RxD_data_ready;
        prevFerr  = RxD_frame_error;
        prevEop   = RxD_endofpacket;
        prevData  = RxD_data;
    end

    function automatic logic [31:0] qGet(input int idx);
        if (idx >= 0 && idx < rxQ.size()) return 32'(rxQ[idx]);
        return 32'h100;
    endfunction

    task automatic driveBit(input logic v, input int n);
        RxD = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input int bitClk, input logic stopVal);
        driveBit(1'b0, bitClk);
        for (int i = 0; i < 8; i++) driveBit(b[i], bitClk);
        driveBit(stopVal, bitClk);
    endtask

    task automatic idleBits(input int n);
        driveBit(1'b1, n * BitClk);
    endtask

    // Aligns the next stimulus edge just after a filter sample so a glitch covers a known tick count.
    task automatic waitTick();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dut.OvTick) found = 1'b1;
        end
        checkVal("tickSeen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkVal({pfx, "Ready"}, 32'(RxD_data_ready), 32'd0);
        checkVal({pfx, "Data"}, 32'(RxD_data), 32'h00);
        checkVal({pfx, "Ferr"}, 32'(RxD_frame_error), 32'd0);
        checkVal({pfx, "Eop"}, 32'(RxD_endofpacket), 32'd0);
        checkVal({pfx, "Idle"}, 32'(RxD_idle), 32'd1);
    endtask

    initial begin
        int rb;
        int fb;
        int eb;
        int qb;
        int firstEop;

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        monOn = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleBits(2);

        // single byte
        rb = readyCnt; fb = ferrCnt; qb = rxQ.size();
        fork
            sendFrame(8'h55, BitClk, 1'b1);
            begin
                repeat (5 * BitClk) @(negedge clk);
                checkVal("idleInFrame", 32'(RxD_idle), 32'd0);
            end
        join
        idleBits(2);
        checkVal("b55Ready", 32'(readyCnt - rb), 32'd1);
        checkVal("b55Data", 32'(RxD_data), 32'h55);
        checkVal("b55Queue", qGet(qb), 32'h55);
        checkVal("b55Ferr", 32'(ferrCnt - fb), 32'd0);

        // back-to-back bytes then end of packet
        rb = readyCnt; eb = eopCnt; qb = rxQ.size();
        sendFrame(8'hA3, BitClk, 1'b1);
        sendFrame(8'h0F, BitClk, 1'b1);
        sendFrame(8'hFF, BitClk, 1'b1);
        RxD = 1'b1;
        firstEop = -1;
        for (int i = 0; i < 20 * BitClk; i++) begin
            @(negedge clk);
            if (RxD_endofpacket && firstEop < 0) firstEop = i;
        end
        @(posedge clk);
        #1;
        checkVal("b2bReady", 32'(readyCnt - rb), 32'd3);
        checkVal("b2bData0", qGet(qb), 32'hA3);
        checkVal("b2bData1", qGet(qb + 1), 32'h0F);
        checkVal("b2bData2", qGet(qb + 2), 32'hFF);
        checkVal("eopCount", 32'(eopCnt - eb), 32'd1);
        checkVal("eopTime", 32'(firstEop >= 15 * BitClk && firstEop <= 17 * BitClk), 32'd1);
        checkVal("idleAfterEop", 32'(RxD_idle), 32'd1);

        // glitch rejection
        rb = readyCnt; fb = ferrCnt; qb = rxQ.size();
        waitTick();
        driveBit(1'b0, GlitchSh);
        idleBits(3);
        checkVal("shortGlitchIdle", 32'(RxD_idle), 32'd1);
        waitTick();
        driveBit(1'b0, GlitchLg);
        idleBits(3);
        checkVal("longGlitchIdle", 32'(RxD_idle), 32'd0);
        checkVal("glitchReady", 32'(readyCnt - rb), 32'd0);
        checkVal("glitchFerr", 32'(ferrCnt - fb), 32'd0);
        sendFrame(8'h81, BitClk, 1'b1);
        idleBits(2);
        checkVal("b81Ready", 32'(readyCnt - rb), 32'd1);
        checkVal("b81Data", 32'(RxD_data), 32'h81);

        // framing error and break
        rb = readyCnt; fb = ferrCnt;
        sendFrame(8'h3C, BitClk, 1'b0);
        driveBit(1'b0, 30 * BitClk);
        checkVal("breakIdle", 32'(RxD_idle), 32'd0);
        checkVal("breakFerr", 32'(ferrCnt - fb), 32'd1);
        checkVal("breakReady", 32'(readyCnt - rb), 32'd0);
        checkVal("breakData", 32'(RxD_data), 32'h81);
        idleBits(2);
        checkVal("releaseFerr", 32'(ferrCnt - fb), 32'd1);
        checkVal("releaseReady", 32'(readyCnt - rb), 32'd0);
        sendFrame(8'h7E, BitClk, 1'b1);
        idleBits(2);
        checkVal("b7eReady", 32'(readyCnt - rb), 32'd1);
        checkVal("b7eData", 32'(RxD_data), 32'h7E);

        // sender baud offsets
        rb = readyCnt; fb = ferrCnt; qb = rxQ.size();
        sendFrame(8'h5A, BitSlow, 1'b1);
        idleBits(2);
        checkVal("slowData", qGet(qb), 32'h5A);
        sendFrame(8'h5A, BitFast, 1'b1);
        idleBits(2);
        checkVal("fastData", qGet(qb + 1), 32'h5A);
        checkVal("baudReady", 32'(readyCnt - rb), 32'd2);
        checkVal("baudFerr", 32'(ferrCnt - fb), 32'd0);

        // reset mid-frame
        idleBits(3);
        rb = readyCnt; fb = ferrCnt;
        fork
            sendFrame(8'hF0, BitClk, 1'b1);
            begin
                repeat (5 * BitClk + BitClk / 3) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                checkResetOutputs("midRst");
            end
        join
        idleBits(2);
        checkVal("abortReady", 32'(readyCnt - rb), 32'd0);
        checkVal("abortFerr", 32'(ferrCnt - fb), 32'd0);
        sendFrame(8'hC3, BitClk, 1'b1);
        idleBits(2);
        checkVal("bc3Ready", 32'(readyCnt - rb), 32'd1);
        checkVal("bc3Data", 32'(RxD_data), 32'hC3);

        // strobe discipline over the whole run
        checkVal("readyAndFerr", 32'(bothHigh), 32'd0);
        checkVal("readyWidth", 32'(readyLong), 32'd0);
        checkVal("ferrWidth", 32'(ferrLong), 32'd0);
        checkVal("eopWidth", 32'(eopLong), 32'd0);
        checkVal("dataHold", 32'(dataGlitch), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
